// File: rtl/axi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_bus_arbiter
// Description : Two-master (ibus/dbus) to one-manager AXI4 arbiter with
//               independent read and write grant FSMs. Define
//               AXI_ARB_ROUND_ROBIN_EN for last-winner fairness per channel;
//               otherwise dbus has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    // ibus subordinate port
    input  logic [3:0]  s_ibus_awid,
    input  logic [31:0] s_ibus_awaddr,
    input  logic [7:0]  s_ibus_awlen,
    input  logic [2:0]  s_ibus_awsize,
    input  logic [1:0]  s_ibus_awburst,
    input  logic [2:0]  s_ibus_awprot,
    input  logic        s_ibus_awvalid,
    output logic        s_ibus_awready,
    input  logic [31:0] s_ibus_wdata,
    input  logic [3:0]  s_ibus_wstrb,
    input  logic        s_ibus_wlast,
    input  logic        s_ibus_wvalid,
    output logic        s_ibus_wready,
    output logic [3:0]  s_ibus_bid,
    output logic [1:0]  s_ibus_bresp,
    output logic        s_ibus_bvalid,
    input  logic        s_ibus_bready,
    input  logic [3:0]  s_ibus_arid,
    input  logic [31:0] s_ibus_araddr,
    input  logic [7:0]  s_ibus_arlen,
    input  logic [2:0]  s_ibus_arsize,
    input  logic [1:0]  s_ibus_arburst,
    input  logic [2:0]  s_ibus_arprot,
    input  logic        s_ibus_arvalid,
    output logic        s_ibus_arready,
    output logic [3:0]  s_ibus_rid,
    output logic [31:0] s_ibus_rdata,
    output logic [1:0]  s_ibus_rresp,
    output logic        s_ibus_rlast,
    output logic        s_ibus_rvalid,
    input  logic        s_ibus_rready,
    // dbus subordinate port
    input  logic [3:0]  s_dbus_awid,
    input  logic [31:0] s_dbus_awaddr,
    input  logic [7:0]  s_dbus_awlen,
    input  logic [2:0]  s_dbus_awsize,
    input  logic [1:0]  s_dbus_awburst,
    input  logic [2:0]  s_dbus_awprot,
    input  logic        s_dbus_awvalid,
    output logic        s_dbus_awready,
    input  logic [31:0] s_dbus_wdata,
    input  logic [3:0]  s_dbus_wstrb,
    input  logic        s_dbus_wlast,
    input  logic        s_dbus_wvalid,
    output logic        s_dbus_wready,
    output logic [3:0]  s_dbus_bid,
    output logic [1:0]  s_dbus_bresp,
    output logic        s_dbus_bvalid,
    input  logic        s_dbus_bready,
    input  logic [3:0]  s_dbus_arid,
    input  logic [31:0] s_dbus_araddr,
    input  logic [7:0]  s_dbus_arlen,
    input  logic [2:0]  s_dbus_arsize,
    input  logic [1:0]  s_dbus_arburst,
    input  logic [2:0]  s_dbus_arprot,
    input  logic        s_dbus_arvalid,
    output logic        s_dbus_arready,
    output logic [3:0]  s_dbus_rid,
    output logic [31:0] s_dbus_rdata,
    output logic [1:0]  s_dbus_rresp,
    output logic        s_dbus_rlast,
    output logic        s_dbus_rvalid,
    input  logic        s_dbus_rready,
    // manager port
    output logic [3:0]  m_axi_awid,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [3:0]  m_axi_bid,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [3:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    // debug
    output logic        rd_owner
);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_t;

    rd_state_t r_rd_state, w_rd_next;
    wr_state_t r_wr_state, w_wr_next;
    logic      r_rd_owner, r_wr_owner;
    logic      w_rd_req, w_wr_req, w_rd_pick, w_wr_pick;
    logic      w_rd_addr, w_rd_data, w_wr_addr, w_wr_data, w_wr_resp;
    logic      w_rd_done, w_wr_done;

    assign w_rd_req  = s_ibus_arvalid | s_dbus_arvalid;
    assign w_wr_req  = s_ibus_awvalid | s_dbus_awvalid;
    assign w_rd_addr = (r_rd_state == RD_ADDR);
    assign w_rd_data = (r_rd_state == RD_DATA);
    assign w_wr_addr = (r_wr_state == WR_ADDR);
    assign w_wr_data = (r_wr_state == WR_DATA);
    assign w_wr_resp = (r_wr_state == WR_RESP);
    assign w_rd_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign w_wr_done = m_axi_bvalid & m_axi_bready;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Last-winner per channel: on a tie the other master gets the grant.
    logic r_rd_last, r_wr_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_last <= 1'b0;
            r_wr_last <= 1'b0;
        end else begin
            if (w_rd_done) r_rd_last <= r_rd_owner;
            if (w_wr_done) r_wr_last <= r_wr_owner;
        end
    end

    assign w_rd_pick = (s_ibus_arvalid & s_dbus_arvalid) ? ~r_rd_last : s_dbus_arvalid;
    assign w_wr_pick = (s_ibus_awvalid & s_dbus_awvalid) ? ~r_wr_last : s_dbus_awvalid;
`else
    assign w_rd_pick = s_dbus_arvalid;
    assign w_wr_pick = s_dbus_awvalid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= RD_IDLE;
            r_wr_state <= WR_IDLE;
            r_rd_owner <= 1'b0;
            r_wr_owner <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            r_wr_state <= w_wr_next;
            if (r_rd_state == RD_IDLE && w_rd_req) r_rd_owner <= w_rd_pick;
            if (r_wr_state == WR_IDLE && w_wr_req) r_wr_owner <= w_wr_pick;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_rd_req)                       w_rd_next = RD_ADDR;
            RD_ADDR: if (m_axi_arvalid & m_axi_arready)  w_rd_next = RD_DATA;
            RD_DATA: if (w_rd_done)                      w_rd_next = RD_IDLE;
            default:                                     w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (w_wr_req)                                     w_wr_next = WR_ADDR;
            WR_ADDR: if (m_axi_awvalid & m_axi_awready)                w_wr_next = WR_DATA;
            WR_DATA: if (m_axi_wvalid & m_axi_wready & m_axi_wlast)    w_wr_next = WR_RESP;
            WR_RESP: if (w_wr_done)                                    w_wr_next = WR_IDLE;
            default:                                                   w_wr_next = WR_IDLE;
        endcase
    end

    assign rd_owner = r_rd_owner;

    // Read address: granted master passes through only while in RD_ADDR.
    assign m_axi_arvalid  = w_rd_addr & (r_rd_owner ? s_dbus_arvalid : s_ibus_arvalid);
    assign m_axi_arid     = w_rd_addr ? (r_rd_owner ? s_dbus_arid    : s_ibus_arid)    : '0;
    assign m_axi_araddr   = w_rd_addr ? (r_rd_owner ? s_dbus_araddr  : s_ibus_araddr)  : '0;
    assign m_axi_arlen    = w_rd_addr ? (r_rd_owner ? s_dbus_arlen   : s_ibus_arlen)   : '0;
    assign m_axi_arsize   = w_rd_addr ? (r_rd_owner ? s_dbus_arsize  : s_ibus_arsize)  : '0;
    assign m_axi_arburst  = w_rd_addr ? (r_rd_owner ? s_dbus_arburst : s_ibus_arburst) : '0;
    assign m_axi_arprot   = w_rd_addr ? (r_rd_owner ? s_dbus_arprot  : s_ibus_arprot)  : '0;
    assign s_ibus_arready = w_rd_addr & ~r_rd_owner & m_axi_arready;
    assign s_dbus_arready = w_rd_addr &  r_rd_owner & m_axi_arready;

    // Read data: payload fans out to both, handshakes only to the owner.
    assign s_ibus_rvalid  = w_rd_data & ~r_rd_owner & m_axi_rvalid;
    assign s_dbus_rvalid  = w_rd_data &  r_rd_owner & m_axi_rvalid;
    assign m_axi_rready   = w_rd_data & (r_rd_owner ? s_dbus_rready : s_ibus_rready);
    assign s_ibus_rid     = m_axi_rid;
    assign s_ibus_rdata   = m_axi_rdata;
    assign s_ibus_rresp   = m_axi_rresp;
    assign s_ibus_rlast   = m_axi_rlast;
    assign s_dbus_rid     = m_axi_rid;
    assign s_dbus_rdata   = m_axi_rdata;
    assign s_dbus_rresp   = m_axi_rresp;
    assign s_dbus_rlast   = m_axi_rlast;

    assign m_axi_awvalid  = w_wr_addr & (r_wr_owner ? s_dbus_awvalid : s_ibus_awvalid);
    assign m_axi_awid     = w_wr_addr ? (r_wr_owner ? s_dbus_awid    : s_ibus_awid)    : '0;
    assign m_axi_awaddr   = w_wr_addr ? (r_wr_owner ? s_dbus_awaddr  : s_ibus_awaddr)  : '0;
    assign m_axi_awlen    = w_wr_addr ? (r_wr_owner ? s_dbus_awlen   : s_ibus_awlen)   : '0;
    assign m_axi_awsize   = w_wr_addr ? (r_wr_owner ? s_dbus_awsize  : s_ibus_awsize)  : '0;
    assign m_axi_awburst  = w_wr_addr ? (r_wr_owner ? s_dbus_awburst : s_ibus_awburst) : '0;
    assign m_axi_awprot   = w_wr_addr ? (r_wr_owner ? s_dbus_awprot  : s_ibus_awprot)  : '0;
    assign s_ibus_awready = w_wr_addr & ~r_wr_owner & m_axi_awready;
    assign s_dbus_awready = w_wr_addr &  r_wr_owner & m_axi_awready;

    // Write data is never buffered: wready is a straight pass-through in WR_DATA.
    assign m_axi_wvalid   = w_wr_data & (r_wr_owner ? s_dbus_wvalid : s_ibus_wvalid);
    assign m_axi_wdata    = w_wr_data ? (r_wr_owner ? s_dbus_wdata : s_ibus_wdata) : '0;
    assign m_axi_wstrb    = w_wr_data ? (r_wr_owner ? s_dbus_wstrb : s_ibus_wstrb) : '0;
    assign m_axi_wlast    = w_wr_data & (r_wr_owner ? s_dbus_wlast : s_ibus_wlast);
    assign s_ibus_wready  = w_wr_data & ~r_wr_owner & m_axi_wready;
    assign s_dbus_wready  = w_wr_data &  r_wr_owner & m_axi_wready;

    assign s_ibus_bvalid  = w_wr_resp & ~r_wr_owner & m_axi_bvalid;
    assign s_dbus_bvalid  = w_wr_resp &  r_wr_owner & m_axi_bvalid;
    assign m_axi_bready   = w_wr_resp & (r_wr_owner ? s_dbus_bready : s_ibus_bready);
    assign s_ibus_bid     = m_axi_bid;
    assign s_ibus_bresp   = m_axi_bresp;
    assign s_dbus_bid     = m_axi_bid;
    assign s_dbus_bresp   = m_axi_bresp;

endmodule
`default_nettype wire
